// File: rtl/histeq_pipe_sequencer.sv
// Wave-based sequencer for a chain of frame-processing stages (histogram, equalize, output).
// Each wave initialises, runs and retires the stages that hold a frame in that wave.
module histeq_pipe_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int FRAME_W    = 8,
  parameter int WDOG_W     = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    StartSignal,
  input  logic [FRAME_W-1:0]      NumFrames,
  input  logic [NUM_STAGES-1:0]   StageFlag,
  output logic [2*NUM_STAGES-1:0] StageControl,
  output logic [1:0]              GlobalFlag,
  output logic [FRAME_W-1:0]      FrameCount
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  localparam int WAVE_W = FRAME_W + 1;
  // One spare bit so s + NumFrames cannot overflow in the activity compare.
  localparam int CMP_W  = WAVE_W + 1;

  logic [2:0]            state_q, state_d;
  logic [WAVE_W-1:0]     wave_q, wave_d;
  logic [FRAME_W-1:0]    nframes_q, nframes_d;
  logic [NUM_STAGES-1:0] sticky_q, sticky_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [FRAME_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                  start_prev_q;

  logic [NUM_STAGES-1:0] active;
  logic [CMP_W-1:0]      wave_ext;
  logic [CMP_W-1:0]      last_wave;
  logic                  start_edge;

  assign wave_ext   = {1'b0, wave_q};
  assign last_wave  = CMP_W'(nframes_q) + CMP_W'(NUM_STAGES - 1) - CMP_W'(1);
  assign start_edge = StartSignal & ~start_prev_q;

  // Stage s holds frame (wave - s) while s <= wave < s + NumFrames.
  always_comb begin
    active = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      active[s] = (wave_ext >= CMP_W'(s)) &&
                  (wave_ext < (CMP_W'(s) + CMP_W'(nframes_q)));
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    wave_d      = wave_q;
    nframes_d   = nframes_q;
    sticky_d    = sticky_q;
    wdog_d      = wdog_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          nframes_d   = NumFrames;
          wave_d      = '0;
          frame_cnt_d = '0;
          sticky_d    = '0;
          state_d     = (NumFrames == '0) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        sticky_d = '0;
        wdog_d   = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        sticky_d = sticky_q | (StageFlag & active);
        wdog_d   = wdog_q + WDOG_W'(1);
        if ((sticky_d & active) == active) begin
          state_d = S_ADVANCE;
        end else if (wdog_d == '1) begin
          state_d = S_ERROR;
        end
      end
      S_ADVANCE: begin
        sticky_d = '0;
        if (active[NUM_STAGES-1]) begin
          frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        end
        wave_d  = wave_q + WAVE_W'(1);
        state_d = (wave_ext == last_wave) ? S_DONE : S_INIT;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wave_q       <= '0;
      nframes_q    <= '0;
      sticky_q     <= '0;
      wdog_q       <= '0;
      frame_cnt_q  <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wave_q       <= wave_d;
      nframes_q    <= nframes_d;
      sticky_q     <= sticky_d;
      wdog_q       <= wdog_d;
      frame_cnt_q  <= frame_cnt_d;
      start_prev_q <= StartSignal;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    StageControl = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (active[s] && state_q == S_INIT) begin
        StageControl[2*s +: 2] = 2'b01;
      end else if (active[s] && state_q == S_RUN) begin
        StageControl[2*s +: 2] = 2'b10;
      end
    end
  end

  always_comb begin
    case (state_q)
      S_INIT, S_RUN, S_ADVANCE: GlobalFlag = 2'b01;
      S_DONE:                   GlobalFlag = 2'b10;
      S_ERROR:                  GlobalFlag = 2'b11;
      default:                  GlobalFlag = 2'b00;
    endcase
  end

  assign FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_histeq_pipe_sequencer.sv
// Scoreboard bench: expected per-wave RUN controls, RUN lengths and frame counts are queued
// when a job is started and compared as the sequencer produces them.
module tb_histeq_pipe_sequencer;

  localparam int NS = 3;
  localparam int FW = 8;
  localparam int WW = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            StartSignal;
  logic [FW-1:0]   NumFrames;
  logic [NS-1:0]   StageFlag;
  logic [2*NS-1:0] StageControl;
  logic [1:0]      GlobalFlag;
  logic [FW-1:0]   FrameCount;

  histeq_pipe_sequencer #(.NUM_STAGES(NS), .FRAME_W(FW), .WDOG_W(WW)) dut (
    .clock        (clock),
    .reset        (reset),
    .StartSignal  (StartSignal),
    .NumFrames    (NumFrames),
    .StageFlag    (StageFlag),
    .StageControl (StageControl),
    .GlobalFlag   (GlobalFlag),
    .FrameCount   (FrameCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2*NS-1:0] ctrl;
    int              len;   // expected RUN cycles, 0 = not checked
  } wave_t;

  wave_t exp_wave_q[$];
  int    exp_fc_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    waves_seen = 0;
  bit    auto_en;
  int    dly [NS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_active(int n, int w, int s);
    return (s <= w) && (w < s + n);
  endfunction

  function automatic logic [2*NS-1:0] model_ctrl(int n, int w);
    logic [2*NS-1:0] c;
    c = '0;
    for (int s = 0; s < NS; s++) if (model_active(n, w, s)) c[2*s +: 2] = 2'b10;
    return c;
  endfunction

  function automatic int model_len(int n, int w);
    int m;
    m = 0;
    for (int s = 0; s < NS; s++) if (model_active(n, w, s) && dly[s] > m) m = dly[s];
    return m;
  endfunction

  task automatic push_wave(input int n, input int w, input int len);
    wave_t e;
    e.ctrl = model_ctrl(n, w);
    e.len  = len;
    exp_wave_q.push_back(e);
  endtask

  task automatic start_job(input int n);
    @(negedge clock);
    NumFrames   = FW'(n);
    StartSignal = 1'b1;
    @(negedge clock);
    StartSignal = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && GlobalFlag !== 2'b10; i++) @(negedge clock);
    check({tag, "_done"}, 32'(GlobalFlag), 32'd2);
    check({tag, "_fc"}, 32'(FrameCount), 32'(exp_fc_q.pop_front()));
    check({tag, "_waves_left"}, 32'(exp_wave_q.size()), 32'd0);
  endtask

  task automatic run_job(input string tag, input int n);
    int base;
    for (int w = 0; w < n + NS - 1; w++) push_wave(n, w, model_len(n, w));
    exp_fc_q.push_back(n);
    base = waves_seen;
    start_job(n);
    wait_done(tag);
    check({tag, "_waves"}, 32'(waves_seen - base), 32'(n + NS - 1));
  endtask

  // Stage model: a stage raises its done flag after dly[s] cycles of run control.
  initial begin
    int cnt [NS];
    for (int s = 0; s < NS; s++) cnt[s] = 0;
    forever begin
      @(negedge clock);
      for (int s = 0; s < NS; s++) begin
        if (StageControl[2*s +: 2] == 2'b10) cnt[s]++;
        else cnt[s] = 0;
        if (auto_en) StageFlag[s] = (cnt[s] >= dly[s]);
      end
    end
  end

  // Monitor: each RUN entry pops one expected wave; each RUN exit checks its length.
  initial begin
    bit    prev_run;
    bit    is_run;
    int    run_len;
    wave_t cur;
    prev_run = 1'b0;
    run_len  = 0;
    cur.ctrl = '0;
    cur.len  = 0;
    forever begin
      @(negedge clock);
      is_run = 1'b0;
      for (int s = 0; s < NS; s++) if (StageControl[2*s +: 2] == 2'b10) is_run = 1'b1;
      if (is_run && !prev_run) begin
        waves_seen++;
        run_len = 0;
        if (exp_wave_q.size() == 0) begin
          cur.len = 0;
          check("unexpected_run", 32'(StageControl), 32'd0);
        end else begin
          cur = exp_wave_q.pop_front();
          check("wave_ctrl", 32'(StageControl), 32'(cur.ctrl));
        end
      end
      if (is_run) run_len++;
      if (!is_run && prev_run && cur.len != 0) check("run_len", 32'(run_len), 32'(cur.len));
      prev_run = is_run;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    reset       = 1'b1;
    StartSignal = 1'b0;
    NumFrames   = '0;
    StageFlag   = '0;
    auto_en     = 1'b1;
    for (int s = 0; s < NS; s++) dly[s] = 5;
    repeat (3) @(negedge clock);
    check("rst_ctrl", 32'(StageControl), 32'd0);
    check("rst_gf", 32'(GlobalFlag), 32'd0);
    check("rst_fc", 32'(FrameCount), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Zero-frame job goes straight to DONE with no stage activity.
    exp_fc_q.push_back(0);
    start_job(0);
    check("t1_fast_done", 32'(GlobalFlag), 32'd2);
    check("t1_ctrl", 32'(StageControl), 32'd0);
    wait_done("t1");

    // One frame: each wave activates exactly one stage.
    run_job("t2", 1);

    // Two frames with unequal stage latencies: advance waits for the slowest active stage.
    dly[0] = 3; dly[1] = 6; dly[2] = 4;
    run_job("t3", 2);
    for (int s = 0; s < NS; s++) dly[s] = 5;

    // Flags from inactive stages are ignored; a one-cycle pulse from stage 0 completes wave 0.
    auto_en = 1'b0;
    StageFlag = '0;
    push_wave(1, 0, 11);
    push_wave(1, 1, 5);
    push_wave(1, 2, 5);
    exp_fc_q.push_back(1);
    start_job(1);
    for (int i = 0; i < 20 && StageControl !== 6'b000010; i++) @(negedge clock);
    check("t4_run", 32'(StageControl), 32'h02);
    StageFlag = 3'b110;
    repeat (9) @(negedge clock);
    check("t4_no_adv", 32'(StageControl), 32'h02);
    @(negedge clock);
    StageFlag = 3'b001;
    @(negedge clock);
    StageFlag = 3'b000;
    check("t4_adv_ctrl", 32'(StageControl), 32'd0);
    check("t4_adv_gf", 32'(GlobalFlag), 32'd1);
    auto_en = 1'b1;
    wait_done("t4");

    // Reset during the RUN of wave 2 clears every output, then a full job runs cleanly.
    push_wave(3, 0, 5);
    push_wave(3, 1, 5);
    push_wave(3, 2, 0);
    base = waves_seen;
    start_job(3);
    for (int i = 0; i < 200 && waves_seen - base < 3; i++) @(negedge clock);
    check("t5_wave2", 32'(waves_seen - base), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("t5_rst_ctrl", 32'(StageControl), 32'd0);
    check("t5_rst_gf", 32'(GlobalFlag), 32'd0);
    check("t5_rst_fc", 32'(FrameCount), 32'd0);
    reset = 1'b0;
    check("t5_q_empty", 32'(exp_wave_q.size()), 32'd0);
    run_job("t6", 2);

    // Watchdog: no flags, ERROR after 15 RUN cycles; start ignored; reset recovers.
    auto_en = 1'b0;
    StageFlag = '0;
    push_wave(1, 0, 15);
    start_job(1);
    for (int i = 0; i < 100 && GlobalFlag !== 2'b11; i++) @(negedge clock);
    check("t7_err_gf", 32'(GlobalFlag), 32'd3);
    check("t7_err_ctrl", 32'(StageControl), 32'd0);
    StartSignal = 1'b1;
    NumFrames   = FW'(2);
    repeat (3) @(negedge clock);
    check("t7_start_ign", 32'(GlobalFlag), 32'd3);
    check("t7_start_ctrl", 32'(StageControl), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset       = 1'b0;
    StartSignal = 1'b0;
    check("t7_rst_gf", 32'(GlobalFlag), 32'd0);
    check("t7_rst_ctrl", 32'(StageControl), 32'd0);
    check("t7_rst_fc", 32'(FrameCount), 32'd0);
    @(negedge clock);
    check("t7_idle_gf", 32'(GlobalFlag), 32'd0);
    check("final_q_empty", 32'(exp_wave_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/histeq_pipe_sequencer.md
HISTEQ_PIPE_SEQUENCER -- requirements
Module: histeq_pipe_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3: number of chained processing stages sequenced (histogram, equalize, output), minimum 1.
REQ-002 SHALL have parameter FRAME_W, default 8: width of frame-count quantities.
REQ-003 SHALL have parameter WDOG_W, default 20: width of the per-wave watchdog counter.
REQ-004 SHALL have port clock  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port StartSignal  input  1: job start request, rising-edge detected.
REQ-007 SHALL have port NumFrames  input  FRAME_W: frames in the job, sampled on the accepted start edge.
REQ-008 SHALL have port StageFlag  input  NUM_STAGES: bit s is stage s's done flag.
REQ-009 SHALL have port StageControl  output  2*NUM_STAGES: bits [2s+1:2s] are stage s's control code.
REQ-010 SHALL have port GlobalFlag  output  2: job status.
REQ-011 SHALL have port FrameCount  output  FRAME_W: frames retired by the last stage in the current or last job.

Function
REQ-012 SHALL use control codes 00 idle, 01 init (clear-stage pulse), 10 run; 11 is never driven.
REQ-013 SHALL encode GlobalFlag as 00 idle, 01 busy, 10 done, 11 error.
REQ-014 SHALL implement states IDLE, INIT, RUN, ADVANCE, DONE, ERROR.
REQ-015 SHALL process frames in waves w = 0 .. NumFrames+NUM_STAGES-2: stage s is active in wave w iff s <= w < s+NumFrames; it processes frame w-s.
REQ-016 SHALL accept a start when, in IDLE or DONE, StartSignal is 1 and was 0 in the previous cycle: latch NumFrames, clear the wave counter and FrameCount; next state is INIT, or DONE directly if NumFrames==0.
REQ-017 SHALL ignore start edges in INIT, RUN, ADVANCE and ERROR.
REQ-018 SHALL, in INIT (exactly one cycle), drive 01 to active stages and 00 to inactive stages, then go to RUN.
REQ-019 SHALL, in RUN, drive 10 to active stages and 00 to inactive stages.
REQ-020 SHALL, in RUN, OR StageFlag of active stages into sticky done bits; StageFlag in other states and from inactive stages SHALL be ignored.
REQ-021 SHALL go from RUN to ADVANCE in the cycle after all active stages' sticky bits, including bits set that same cycle, are 1.
REQ-022 SHALL, in ADVANCE (one cycle, all controls 00), clear the sticky bits, increment FrameCount if stage NUM_STAGES-1 was active, and increment the wave counter.
REQ-023 SHALL, after ADVANCE, go to DONE if the wave just finished was the last wave, else to INIT.
REQ-024 SHALL, in DONE, hold all controls at 00 and GlobalFlag at 10 until an accepted start.
REQ-025 SHALL drive GlobalFlag 01 in INIT, RUN and ADVANCE, and 00 in IDLE.
REQ-026 SHALL have a watchdog that clears on entry to RUN and increments each RUN cycle; on reaching all-ones it SHALL enter ERROR.
REQ-027 SHALL, in ERROR, drive all controls 00 and GlobalFlag 11, and stay there until reset.
REQ-028 SHALL use wave counter width FRAME_W+1 so the maximum wave count, 2^FRAME_W-1+NUM_STAGES-1, does not wrap.
REQ-029 SHALL make all outputs registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-030 SHALL, when reset is 1 on a clock edge, enter IDLE; StageControl=0, GlobalFlag=00, FrameCount=0, sticky bits, watchdog, wave counter and start-edge history=0.
REQ-031 SHALL give reset priority over every other event, including reset asserted mid-job, during ERROR, or together with a start edge.

Verification (NUM_STAGES=3, FRAME_W=8)
REQ-032 SHALL verify: NumFrames=1, start edge, each active stage raises its flag 5 cycles into RUN -> waves 0/1/2 activate only stage 0/1/2 (StageControl 000010, 001000, 100000 in RUN), then DONE, GlobalFlag=10, FrameCount=1.
REQ-033 SHALL verify: NumFrames=2 -> wave 1 drives 001010 in RUN, with stages 0 and 1 concurrent; advance waits for the later flag; 4 waves total; FrameCount=2.
REQ-034 SHALL verify: NumFrames=0 -> DONE within 2 cycles of the edge, StageControl never nonzero, FrameCount=0.
REQ-035 SHALL verify: in wave 0, StageFlag=3'b110 held through RUN (inactive stages only) -> no advance; flag bit 0 pulsed for one cycle -> ADVANCE next cycle.
REQ-036 SHALL verify: WDOG_W=4, no flags -> ERROR after 15 RUN cycles, GlobalFlag=11; a start edge is ignored; reset returns to IDLE with GlobalFlag=00.
REQ-037 SHALL verify: reset asserted during RUN of wave 2 -> next cycle all outputs 0; a new start then runs a full job correctly.
